// File: rtl/ps2_direction_decoder.sv
// Turns PS/2 set-2 scan-code bytes into held direction buttons plus step pulses,
// with E0/F0 prefix tracking, typematic suppression and optional auto-repeat.
module ps2_direction_decoder #(
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter bit          WASD_EN        = 1'b1,
  parameter bit          KEYPAD_EN      = 1'b1,
  parameter int unsigned REPEAT_CYCLES  = 2500000,
  parameter int unsigned PREFIX_TIMEOUT = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       btn_up,
  output logic       btn_down,
  output logic       btn_left,
  output logic       btn_right,
  output logic       step_up,
  output logic       step_down,
  output logic       step_left,
  output logic       step_right,
  output logic [3:0] held
);

  localparam int unsigned CW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam int unsigned TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] RLOAD = CW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(PREFIX_TIMEOUT - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGotE0   = 2'd1;
  localparam logic [1:0] StGotF0   = 2'd2;
  localparam logic [1:0] StGotE0F0 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    held_q, held_d;
  logic [3:0]    step_q, step_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic       is_ext, is_brk, code_ev, bat;
  logic [3:0] dir;

  // Direction vector order is {up, down, left, right}.
  always_comb begin
    dir     = 4'b0000;
    is_ext  = (state_q == StGotE0) || (state_q == StGotE0F0);
    is_brk  = (state_q == StGotF0) || (state_q == StGotE0F0);
    code_ev = ps2_key_pressed && (ps2_key_data != 8'hE0) && (ps2_key_data != 8'hF0);
    bat     = code_ev && (state_q == StIdle) && (ps2_key_data == 8'hAA);
    case (ps2_key_data)
      8'h75:   if (is_ext || KEYPAD_EN) dir = 4'b1000;
      8'h72:   if (is_ext || KEYPAD_EN) dir = 4'b0100;
      8'h6B:   if (is_ext || KEYPAD_EN) dir = 4'b0010;
      8'h74:   if (is_ext || KEYPAD_EN) dir = 4'b0001;
      8'h1D:   if (!is_ext && WASD_EN) dir = 4'b1000;
      8'h1B:   if (!is_ext && WASD_EN) dir = 4'b0100;
      8'h1C:   if (!is_ext && WASD_EN) dir = 4'b0010;
      8'h23:   if (!is_ext && WASD_EN) dir = 4'b0001;
      default: dir = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    if (ps2_key_pressed) begin
      if (ps2_key_data == 8'hE0) begin
        state_d = StGotE0;
      end else if (ps2_key_data == 8'hF0) begin
        state_d = is_ext ? StGotE0F0 : StGotF0;
      end else begin
        state_d = StIdle;
      end
    end else if ((state_q != StIdle) && (PREFIX_TIMEOUT != 0)) begin
      if (tcnt_q == TLAST) begin
        state_d = StIdle;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // A break or BAT in the same cycle as a repeat expiry wins and drops the pulse.
  always_comb begin
    held_d = held_q;
    step_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((REPEAT_CYCLES != 0) && held_q[i]) begin
        if (cnt_q[i] == CW'(1)) begin
          step_d[i] = 1'b1;
          cnt_d[i]  = RLOAD;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
      if (bat || (code_ev && is_brk && dir[i])) begin
        held_d[i] = 1'b0;
        step_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (code_ev && !is_brk && dir[i] && !held_q[i]) begin
        held_d[i] = 1'b1;
        step_d[i] = 1'b1;
        cnt_d[i]  = RLOAD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      held_q  <= 4'b0000;
      step_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      held_q  <= held_d;
      step_q  <= step_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign held       = held_q;
  assign step_up    = step_q[3];
  assign step_down  = step_q[2];
  assign step_left  = step_q[1];
  assign step_right = step_q[0];
  assign btn_up     = held_q[3] ^ BTN_ACTIVE_LOW;
  assign btn_down   = held_q[2] ^ BTN_ACTIVE_LOW;
  assign btn_left   = held_q[1] ^ BTN_ACTIVE_LOW;
  assign btn_right  = held_q[0] ^ BTN_ACTIVE_LOW;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench: several decoder configurations share one byte stream; each phase
// resets them and checks the instance whose parameters that phase targets.
module tb_ps2_direction_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       pressed = 1'b0;

  int checks = 0;
  int failures = 0;
  int r0_left_pulses = 0;
  int r16_right_pulses = 0;
  int base;

  logic [3:0] d_btn, d_step, d_held;
  logic [3:0] r0_btn, r0_step, r0_held;
  logic [3:0] r16_btn, r16_step, r16_held;
  logic [3:0] nw_btn, nw_step, nw_held;
  logic [3:0] kp_btn, kp_step, kp_held;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (r0_step[1]) r0_left_pulses++;
    if (r16_step[0]) r16_right_pulses++;
  end

  ps2_direction_decoder u_def (
    .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .btn_up(d_btn[3]), .btn_down(d_btn[2]), .btn_left(d_btn[1]), .btn_right(d_btn[0]),
    .step_up(d_step[3]), .step_down(d_step[2]), .step_left(d_step[1]),
    .step_right(d_step[0]), .held(d_held)
  );

  ps2_direction_decoder #(.REPEAT_CYCLES(0)) u_r0 (
    .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .btn_up(r0_btn[3]), .btn_down(r0_btn[2]), .btn_left(r0_btn[1]), .btn_right(r0_btn[0]),
    .step_up(r0_step[3]), .step_down(r0_step[2]), .step_left(r0_step[1]),
    .step_right(r0_step[0]), .held(r0_held)
  );

  ps2_direction_decoder #(.REPEAT_CYCLES(16)) u_r16 (
    .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .btn_up(r16_btn[3]), .btn_down(r16_btn[2]), .btn_left(r16_btn[1]),
    .btn_right(r16_btn[0]), .step_up(r16_step[3]), .step_down(r16_step[2]),
    .step_left(r16_step[1]), .step_right(r16_step[0]), .held(r16_held)
  );

  ps2_direction_decoder #(.WASD_EN(1'b0)) u_nw (
    .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .btn_up(nw_btn[3]), .btn_down(nw_btn[2]), .btn_left(nw_btn[1]), .btn_right(nw_btn[0]),
    .step_up(nw_step[3]), .step_down(nw_step[2]), .step_left(nw_step[1]),
    .step_right(nw_step[0]), .held(nw_held)
  );

  ps2_direction_decoder #(.KEYPAD_EN(1'b0), .PREFIX_TIMEOUT(8)) u_kp (
    .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .btn_up(kp_btn[3]), .btn_down(kp_btn[2]), .btn_left(kp_btn[1]), .btn_right(kp_btn[0]),
    .step_up(kp_step[3]), .step_down(kp_step[2]), .step_left(kp_step[1]),
    .step_right(kp_step[0]), .held(kp_held)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled by the next posedge and the
  // task returns at the following negedge, where registered results are visible.
  task automatic send(input logic [7:0] b);
    data = b;
    pressed = 1'b1;
    @(negedge clk);
    pressed = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset values, with a strobe during reset that must be ignored.
    @(negedge clk);
    send(8'h1D);
    tick(1);
    chk("rst_held", d_held, 4'b0000);
    chk("rst_btn", d_btn, 4'b1111);
    chk("rst_step", d_step, 4'b0000);
    chk("rst_r16_btn", r16_btn, 4'b1111);
    rst = 1'b0;
    tick(1);
    chk("rst_strobe_ignored", d_held, 4'b0000);

    // Extended up make then break.
    send(8'hE0);
    send(8'h75);
    chk("ext_up_held", d_held, 4'b1000);
    chk("ext_up_btn", d_btn, 4'b0111);
    chk("ext_up_step", d_step, 4'b1000);
    tick(1);
    chk("ext_up_step_one_cycle", d_step, 4'b0000);
    chk("ext_up_still_held", d_held, 4'b1000);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_up_break_held", d_held, 4'b0000);
    chk("ext_up_break_btn", d_btn, 4'b1111);
    chk("ext_up_break_step", d_step, 4'b0000);

    // Stray F0 dropped by a following E0.
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    chk("stray_f0_make", d_held, 4'b1000);

    // No auto-repeat: typematic makes produce a single step.
    do_reset();
    base = r0_left_pulses;
    for (int k = 0; k < 5; k++) begin
      send(8'hE0);
      send(8'h6B);
      chk("r0_btn_left", r0_btn[1], 1'b0);
      tick(998);
      chk("r0_held", r0_held, 4'b0010);
    end
    chk("r0_single_step", r0_left_pulses - base, 1);

    // Auto-repeat every 16 cycles, break ends the train.
    do_reset();
    base = r16_right_pulses;
    send(8'hE0);
    send(8'h74);
    chk("r16_first_step", r16_step[0], 1'b1);
    for (int j = 2; j <= 48; j++) begin
      tick(1);
      chk("r16_step_train", r16_step[0], (j == 17) || (j == 33));
    end
    send(8'hE0);
    chk("r16_step_n49", r16_step[0], 1'b1);
    send(8'hF0);
    chk("r16_held_n50", r16_held, 4'b0001);
    send(8'h74);
    chk("r16_break_held", r16_held, 4'b0000);
    chk("r16_break_btn", r16_btn[0], 1'b1);
    tick(40);
    chk("r16_pulse_total", r16_right_pulses - base, 4);

    // WASD enabled vs disabled.
    do_reset();
    send(8'h1D);
    chk("wasd_up_held", d_held, 4'b1000);
    chk("wasd_up_step", d_step, 4'b1000);
    chk("nowasd_held", nw_held, 4'b0000);
    chk("nowasd_btn", nw_btn, 4'b1111);
    send(8'hF0);
    send(8'h1D);
    chk("wasd_release", d_held, 4'b0000);
    chk("nowasd_step", nw_step, 4'b0000);

    // Prefix timeout with keypad mapping disabled.
    do_reset();
    send(8'hE0);
    tick(9);
    send(8'h72);
    chk("timeout_discard", kp_held, 4'b0000);
    send(8'hE0);
    tick(3);
    send(8'h72);
    chk("short_gap_down", kp_held, 4'b0100);
    send(8'hE0);
    send(8'hF0);
    send(8'h72);
    chk("short_gap_release", kp_held, 4'b0000);
    send(8'hE0);
    tick(7);
    send(8'h72);
    chk("gap7_still_ext", kp_held, 4'b0100);

    // BAT clears everything; reset mid-hold.
    do_reset();
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'h6B);
    chk("two_held", d_held, 4'b1010);
    send(8'hAA);
    chk("bat_clear_held", d_held, 4'b0000);
    chk("bat_clear_btn", d_btn, 4'b1111);
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'h6B);
    rst = 1'b1;
    tick(1);
    chk("midhold_rst_held", d_held, 4'b0000);
    chk("midhold_rst_btn", d_btn, 4'b1111);
    chk("midhold_rst_step", d_step, 4'b0000);
    rst = 1'b0;
    tick(1);
    chk("rst_release_step", d_step, 4'b0000);
    chk("rst_release_held", d_held, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
